// File: rtl/mul54_arbiter.sv
// Shares one 3-stage Mul54 multiply-add pipe between two requesters with
// round-robin arbitration, an optional multi-op lock and operand-latch reuse.
module mul54_arbiter #(
  parameter int A_W = 54,
  parameter int C_W = 105
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic           req0_lock,
  input  logic           req0_keep_a,
  input  logic           req0_keep_b,
  input  logic [A_W-1:0] req0_a,
  input  logic [A_W-1:0] req0_b,
  input  logic [C_W-1:0] req0_c,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic           req1_lock,
  input  logic           req1_keep_a,
  input  logic           req1_keep_b,
  input  logic [A_W-1:0] req1_a,
  input  logic [A_W-1:0] req1_b,
  input  logic [C_W-1:0] req1_c,
  output logic           resp0_valid,
  output logic           resp1_valid,
  output logic [C_W-1:0] resp_data,
  output logic           mul_val_s0,
  output logic           mul_latch_a_s0,
  output logic [A_W-1:0] mul_a_s0,
  output logic           mul_latch_b_s0,
  output logic [A_W-1:0] mul_b_s0,
  output logic [C_W-1:0] mul_c_s2,
  input  logic [C_W-1:0] mul_result_s3,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_RR    = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           rr_ptr_q, rr_ptr_d;
  logic           owner_vld_q, owner_vld_d;
  logic           owner_id_q, owner_id_d;
  logic           init_q;
  logic           v_s1_q, v_s2_q, v_s3_q;
  logic           id_s1_q, id_s2_q, id_s3_q;
  logic [C_W-1:0] c_s1_q, c_s2_q;

  logic           en_s;
  logic           gnt_vld_s;
  logic           gnt_id_s;
  logic           issue_s;
  logic           sel_lock_s;
  logic           sel_keep_a_s;
  logic           sel_keep_b_s;
  logic           reuse_ok_s;

  // init_q holds the block quiet for one cycle after reset is released.
  assign en_s    = reset & init_q;
  assign issue_s = en_s & gnt_vld_s;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_RR;
      rr_ptr_q    <= 1'b0;
      owner_vld_q <= 1'b0;
      owner_id_q  <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_vld_q <= owner_vld_d;
      owner_id_q  <= owner_id_d;
      init_q      <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_vld_d = owner_vld_q;
    owner_id_d  = owner_id_q;
    if (issue_s) begin
      rr_ptr_d    = ~gnt_id_s;
      owner_vld_d = 1'b1;
      owner_id_d  = gnt_id_s;
    end else begin
      rr_ptr_d    = rr_ptr_q;
    end
    case (state_q)
      ST_RR: begin
        if (issue_s && sel_lock_s) begin
          state_d = gnt_id_s ? ST_LOCK1 : ST_LOCK0;
        end else begin
          state_d = ST_RR;
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        if (issue_s && !sel_lock_s) begin
          state_d = ST_RR;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_RR;
    endcase
  end

  // Output logic: grant selection and operand steering
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_id_s  = 1'b0;
    case (state_q)
      ST_RR: begin
        if (req0_valid && req1_valid) begin
          gnt_vld_s = 1'b1;
          gnt_id_s  = rr_ptr_q;
        end else if (req0_valid) begin
          gnt_vld_s = 1'b1;
          gnt_id_s  = 1'b0;
        end else if (req1_valid) begin
          gnt_vld_s = 1'b1;
          gnt_id_s  = 1'b1;
        end else begin
          gnt_vld_s = 1'b0;
        end
      end
      ST_LOCK0: begin
        gnt_vld_s = req0_valid;
        gnt_id_s  = 1'b0;
      end
      ST_LOCK1: begin
        gnt_vld_s = req1_valid;
        gnt_id_s  = 1'b1;
      end
      default: begin
        gnt_vld_s = 1'b0;
        gnt_id_s  = 1'b0;
      end
    endcase
  end

  assign sel_lock_s   = gnt_id_s ? req1_lock   : req0_lock;
  assign sel_keep_a_s = gnt_id_s ? req1_keep_a : req0_keep_a;
  assign sel_keep_b_s = gnt_id_s ? req1_keep_b : req0_keep_b;
  // A held operand is only trusted if the same requester issued the last op.
  assign reuse_ok_s   = owner_vld_q & (owner_id_q == gnt_id_s);

  assign req0_ready     = issue_s & ~gnt_id_s;
  assign req1_ready     = issue_s & gnt_id_s;
  assign mul_val_s0     = issue_s;
  assign mul_latch_a_s0 = issue_s & ~(sel_keep_a_s & reuse_ok_s);
  assign mul_latch_b_s0 = issue_s & ~(sel_keep_b_s & reuse_ok_s);
  assign mul_a_s0       = gnt_id_s ? req1_a : req0_a;
  assign mul_b_s0       = gnt_id_s ? req1_b : req0_b;
  assign mul_c_s2       = c_s2_q;

  // Tag pipe tracking which requester owns each stage
  always_ff @(posedge clock) begin
    if (!reset) begin
      v_s1_q  <= 1'b0;
      v_s2_q  <= 1'b0;
      v_s3_q  <= 1'b0;
      id_s1_q <= 1'b0;
      id_s2_q <= 1'b0;
      id_s3_q <= 1'b0;
    end else begin
      v_s1_q  <= issue_s;
      v_s2_q  <= v_s1_q;
      v_s3_q  <= v_s2_q;
      id_s1_q <= gnt_id_s;
      id_s2_q <= id_s1_q;
      id_s3_q <= id_s2_q;
    end
  end

  // Addend staging to meet the multiplier at s2
  always_ff @(posedge clock) begin
    if (issue_s) begin
      c_s1_q <= gnt_id_s ? req1_c : req0_c;
    end else begin
      c_s1_q <= c_s1_q;
    end
    c_s2_q <= c_s1_q;
  end

  assign resp0_valid = en_s & v_s3_q & ~id_s3_q;
  assign resp1_valid = en_s & v_s3_q & id_s3_q;
  assign resp_data   = mul_result_s3;
  assign busy        = en_s & (v_s1_q | v_s2_q | v_s3_q | (state_q != ST_RR));

endmodule

// File: doc/mul54_arbiter.md
Name: mul54_arbiter

Overview:
- Shares one 3-stage Mul54 multiply-add pipe (a*b+c, operands at s0, addend at s2, result at s3) between two requesters: req0 (div/sqrt sequencer, high iteration rate) and req1 (auxiliary / test port).
- Performs round-robin arbitration with an optional multi-op lock.
- Drives the Mul54 operand-latch enables, including operand reuse.
- Stages the addend to s2 and routes each s3 result back to the requester that issued it.

Parameters:
- A_W, 54, multiplier operand width.
- C_W, 105, addend/result width (2*A_W-3; product truncated to C_W, matching Mul54).

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous reset, active-low: arbiter state clears on a rising clock edge while reset==0.
- req0_valid  in  1  req0 has an op.
- req0_ready  out  1  req0 op accepted this cycle (issue when valid&ready).
- req0_lock  in  1  keep the grant after this op.
- req0_keep_a  in  1  reuse the A operand held in the multiplier.
- req0_keep_b  in  1  reuse the B operand held in the multiplier.
- req0_a  in  A_W  operand A.
- req0_b  in  A_W  operand B.
- req0_c  in  C_W  addend.
- req1_*  same set as req0_* for requester 1.
- resp0_valid  out  1  result for req0 (no backpressure).
- resp1_valid  out  1  result for req1 (no backpressure).
- resp_data  out  C_W  shared result bus = mul_result_s3.
- mul_val_s0  out  1  to Mul54 io_val_s0.
- mul_latch_a_s0  out  1  to Mul54 io_latch_a_s0.
- mul_a_s0  out  A_W  to Mul54 io_a_s0.
- mul_latch_b_s0  out  1  to Mul54 io_latch_b_s0.
- mul_b_s0  out  A_W  to Mul54 io_b_s0.
- mul_c_s2  out  C_W  to Mul54 io_c_s2.
- mul_result_s3  in  C_W  from Mul54 io_result_s3.
- busy  out  1  any op in flight or lock held.

Behaviour:
- Reset (reset==0 at an edge):
  - state=RR, rr_ptr=0 (req0 preferred), last_owner=NONE.
  - Pipe valids s1/s2/s3 cleared.
  - All *_ready, resp*_valid, mul_val_s0 and busy are 0 while reset==0 and in the first cycle after.
  - c staging registers are not reset.
- States:
  - RR: grant the requester whose valid is set. If both are set, grant rr_ptr's requester. On issue, rr_ptr points to the other requester.
  - LOCK0 / LOCK1: only the lock owner may be granted; the other requester's ready is 0.
  - Transitions: RR->LOCKn on issue by n with lockn=1. LOCKn->RR on issue by n with lockn=0. LOCKn holds while the owner is idle (no timeout).
- Issue is combinational within the cycle:
  - ready to the granted requester = its valid.
  - mul_val_s0 = issue; mul_a_s0/mul_b_s0 = granted requester's operands.
  - At most one issue per cycle. Back-to-back issues every cycle are allowed (full throughput).
- Operand reuse:
  - mul_latch_a_s0 = issue & (~keep_a | last_owner != issuer). Same rule for B with keep_b.
  - A keep request is therefore silently overridden after reset or after an op from the other requester. Requesters always drive valid a/b.
  - last_owner updates to the issuer on every issue.
- Addend staging: c_s1 <= granted c on issue; c_s2 <= c_s1. mul_c_s2 = c_s2.
- Tag pipe: {v,id} shifts s1->s2->s3 every cycle, with bubbles recorded as v=0.
- Response:
  - An op issued in cycle T produces resp{id}_valid=1 in cycle T+3, with resp_data = a*b+c mod 2^C_W.
  - resp0_valid and resp1_valid are never both 1.
- busy = v_s1 | v_s2 | v_s3 | (state!=RR).
- Reset mid-operation: in-flight tags are dropped and no response is produced for them. Stale Mul54 contents are never reported.
- Lock owner deasserting valid does not release the lock; only an issue with lock=0 does.

Test Plan:
- Single op: after reset, req0 a=3, b=5, c=7, issue at T -> resp0_valid only at T+3, resp_data=22; mul_latch_a_s0=mul_latch_b_s0=1 at T.
- Contention: both valid continuously, each op a=id+1, b=1, c=0 -> grants alternate 0,1,0,1 (first grant req0); resp0/resp1 alternate starting at T+3; throughput one op per cycle.
- Lock: req0 issues 3 ops with lock=1,1,0 while req1 is valid -> req1_ready=0 until the cycle after req0's lock=0 issue; state returns to RR and req1 issues next.
- Operand reuse: req0 issues a=10, b=2, then keep_a=1 with a=0xFFF, b=4, c=1 -> second mul_latch_a_s0=0, result 41. Then req1 issues, then req0 keep_a=1 -> latch_a forced to 1.
- Reset mid-flight: issue at T, pull reset low at T+1 -> no resp*_valid at T+3; busy=0 after reset; first post-reset keep_a is overridden.
- Width boundary: a=b=2^54-1, c=2^105-1 -> resp_data = ((2^54-1)^2 + 2^105-1) mod 2^105.
